// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM states, default width
// and the fixed results returned on a divide by zero.
package cdim_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // A zero divisor returns an all-ones quotient; the remainder is the raw dividend.
  localparam logic DIV0_QUO_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_iter_if.sv
// Handshake between the execute stage / hazard unit and the divider.
interface div_iter_if import cdim_div_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             div_start;
  logic             div_signed;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             e_advance;
  logic             flush;
  logic             div_stall;
  logic             div_valid;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  modport master (
    output div_start, div_signed, div_a, div_b, e_advance, flush,
    input  div_stall, div_valid, div_hi, div_lo
  );

  modport slave (
    input  div_start, div_signed, div_a, div_b, e_advance, flush,
    output div_stall, div_valid, div_hi, div_lo
  );

endinterface

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU. Quotient goes to LO,
// remainder to HI; stalls the pipeline while a divide is in flight.
module div_iter import cdim_div_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic       clk,
  input logic       resetn,
  div_iter_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef struct packed {
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
  } step_t;

  // One restoring step: shift {rem, quo} left, try rem - divisor, keep it if non-negative.
  function automatic step_t restore_step(input logic [WIDTH-1:0] cur_rem,
                                         input logic [WIDTH-1:0] cur_quo,
                                         input logic [WIDTH-1:0] divisor);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    step_t          res;
    shifted = {cur_rem, cur_quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    res.quo = {cur_quo[WIDTH-2:0], ~trial[WIDTH]};
    res.rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    return res;
  endfunction

  div_state_e       state;
  div_state_e       next_state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] divisor_q;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             start_ok;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  step_t            nxt;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    start_ok = bus.div_start & ~bus.flush;
    a_neg    = bus.div_signed & bus.div_a[WIDTH-1];
    b_neg    = bus.div_signed & bus.div_b[WIDTH-1];
    a_abs    = a_neg ? -bus.div_a : bus.div_a;
    b_abs    = b_neg ? -bus.div_b : bus.div_b;
    nxt      = restore_step(rem_q, quo_q, divisor_q);
    quo_fix  = q_neg ? -nxt.quo : nxt.quo;
    rem_fix  = r_neg ? -nxt.rem : nxt.rem;
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Flush beats everything; a dropped div_start in BUSY means the instruction left E.
  always_comb begin
    next_state = state;
    if (bus.flush) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE: if (bus.div_start) next_state = (b_abs == '0) ? DONE : BUSY;
        BUSY: begin
          if (!bus.div_start)          next_state = IDLE;
          else if (count == LAST_STEP) next_state = DONE;
        end
        DONE: if (bus.e_advance) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (bus.flush) begin
      count <= '0;
    end else begin
      unique case (state)
        IDLE: if (start_ok) begin
          divisor_q <= b_abs;
          q_neg     <= a_neg ^ b_neg;
          r_neg     <= a_neg;
          rem_q     <= '0;
          quo_q     <= a_abs;
          count     <= '0;
          if (b_abs == '0) begin
            hi_q <= bus.div_a;
            lo_q <= {WIDTH{DIV0_QUO_FILL}};
          end
        end
        BUSY: begin
          if (!bus.div_start) begin
            count <= '0;
          end else begin
            rem_q <= nxt.rem;
            quo_q <= nxt.quo;
            if (count == LAST_STEP) begin
              count <= '0;
              hi_q  <= rem_fix;
              lo_q  <= quo_fix;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.div_stall = bus.div_start & ~bus.flush & (state != DONE);
  assign bus.div_valid = (state == DONE);
  assign bus.div_hi    = hi_q;
  assign bus.div_lo    = lo_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed testbench for div_iter: unsigned/signed divides, divide by zero,
// flush, DONE hold and mid-operation reset.
module tb_div_iter;

  logic clk = 1'b0;
  logic resetn;
  int   tests_run = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(32)) bus ();

  div_iter #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  // Starts a divide and waits until the first DONE cycle (sampled on the falling edge).
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic adv, output int stalls, output logic [31:0] hi,
                        output logic [31:0] lo, output logic stall_done,
                        output logic timed_out);
    stalls = 0;
    hi = '0;
    lo = '0;
    stall_done = 1'b1;
    timed_out = 1'b1;
    @(posedge clk); #1;
    bus.div_start  = 1'b1;
    bus.div_signed = sgn;
    bus.div_a      = a;
    bus.div_b      = b;
    bus.e_advance  = adv;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.div_valid) begin
        hi = bus.div_hi;
        lo = bus.div_lo;
        stall_done = bus.div_stall;
        timed_out = 1'b0;
        break;
      end
      if (bus.div_stall) stalls++;
    end
  endtask

  // Caller has e_advance high in the DONE cycle; drop div_start once back in IDLE.
  task automatic release_div(output logic valid_after);
    @(posedge clk); #1;
    bus.div_start = 1'b0;
    @(negedge clk);
    valid_after = bus.div_valid;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.div_start = 1'b0; bus.div_signed = 1'b0; bus.div_a = '0; bus.div_b = '0;
    bus.e_advance = 1'b0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.div_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b want 0", bus.div_valid); end
    tests_run++;
    if (bus.div_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got %b want 0", bus.div_stall); end
    tests_run++;
    if (bus.div_hi !== 32'h0 || bus.div_lo !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_hilo got %h/%h want 0/0", bus.div_hi, bus.div_lo);
    end
  endtask

  task automatic test_divu();
    int stalls; logic [31:0] hi, lo; logic sd, to, va;
    do_div(1'b0, 32'd100, 32'd7, 1'b1, stalls, hi, lo, sd, to);
    tests_run++;
    if (to !== 1'b0) begin failures++; $display("[TB] FAIL divu_timeout got %b want 0", to); end
    tests_run++;
    if (stalls != 33) begin failures++; $display("[TB] FAIL divu_stall_cycles got %0d want 33", stalls); end
    tests_run++;
    if (lo !== 32'd14 || hi !== 32'd2) begin failures++; $display("[TB] FAIL divu_result got lo=%0d hi=%0d want 14/2", lo, hi); end
    tests_run++;
    if (sd !== 1'b0) begin failures++; $display("[TB] FAIL divu_stall_in_done got %b want 0", sd); end
    release_div(va);
    tests_run++;
    if (va !== 1'b0) begin failures++; $display("[TB] FAIL divu_valid_one_cycle got %b want 0", va); end
  endtask

  task automatic test_signed();
    int stalls; logic [31:0] hi, lo; logic sd, to, va;
    logic [31:0] a_vec [3] = '{32'hFFFFFFF9, 32'h80000000, 32'd7};
    logic [31:0] b_vec [3] = '{32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] q_vec [3] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFD};
    logic [31:0] r_vec [3] = '{32'hFFFFFFFF, 32'h0, 32'd1};
    for (int i = 0; i < 3; i++) begin
      do_div(1'b1, a_vec[i], b_vec[i], 1'b1, stalls, hi, lo, sd, to);
      tests_run++;
      if (to !== 1'b0 || stalls != 33) begin
        failures++; $display("[TB] FAIL div_signed_timing[%0d] got timeout=%b stalls=%0d want 0/33", i, to, stalls);
      end
      tests_run++;
      if (lo !== q_vec[i] || hi !== r_vec[i]) begin
        failures++; $display("[TB] FAIL div_signed_result[%0d] got lo=%h hi=%h want %h/%h", i, lo, hi, q_vec[i], r_vec[i]);
      end
      release_div(va);
    end
  endtask

  task automatic test_div_zero();
    int stalls; logic [31:0] hi, lo; logic sd, to, va;
    do_div(1'b0, 32'd5, 32'd0, 1'b1, stalls, hi, lo, sd, to);
    tests_run++;
    if (to !== 1'b0 || stalls != 1) begin failures++; $display("[TB] FAIL divu_zero_timing got timeout=%b stalls=%0d want 0/1", to, stalls); end
    tests_run++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'd5) begin failures++; $display("[TB] FAIL divu_zero_result got lo=%h hi=%h want ffffffff/5", lo, hi); end
    release_div(va);
    do_div(1'b1, 32'hFFFFFFF0, 32'd0, 1'b1, stalls, hi, lo, sd, to);
    tests_run++;
    if (to !== 1'b0 || stalls != 1 || lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF0) begin
      failures++; $display("[TB] FAIL div_zero_signed got stalls=%0d lo=%h hi=%h want 1/ffffffff/fffffff0", stalls, lo, hi);
    end
    release_div(va);
  endtask

  task automatic test_flush();
    int stalls; logic [31:0] hi, lo; logic sd, to, va;
    logic seen_valid;
    @(posedge clk); #1;
    bus.div_start = 1'b1; bus.div_signed = 1'b0; bus.div_a = 32'd1000; bus.div_b = 32'd3; bus.e_advance = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.div_stall !== 1'b0) begin failures++; $display("[TB] FAIL flush_stall got %b want 0", bus.div_stall); end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.div_start = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.div_valid) seen_valid = 1'b1;
    end
    tests_run++;
    if (seen_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got %b want 0", seen_valid); end
    tests_run++;
    if (bus.div_lo !== 32'hFFFFFFFF || bus.div_hi !== 32'hFFFFFFF0) begin
      failures++; $display("[TB] FAIL flush_hilo_kept got %h/%h want ffffffff/fffffff0", bus.div_lo, bus.div_hi);
    end
    do_div(1'b0, 32'd9, 32'd3, 1'b1, stalls, hi, lo, sd, to);
    tests_run++;
    if (to !== 1'b0 || stalls != 33 || lo !== 32'd3 || hi !== 32'd0) begin
      failures++; $display("[TB] FAIL after_flush_divu got stalls=%0d lo=%0d hi=%0d want 33/3/0", stalls, lo, hi);
    end
    release_div(va);
  endtask

  task automatic test_hold();
    int stalls; logic [31:0] hi, lo; logic sd, to, va;
    do_div(1'b0, 32'd50, 32'd5, 1'b0, stalls, hi, lo, sd, to);
    tests_run++;
    if (to !== 1'b0 || stalls != 33) begin failures++; $display("[TB] FAIL hold_timing got timeout=%b stalls=%0d want 0/33", to, stalls); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.div_valid !== 1'b1 || bus.div_stall !== 1'b0 || bus.div_lo !== 32'd10 || bus.div_hi !== 32'd0) begin
        failures++;
        $display("[TB] FAIL hold_done[%0d] got valid=%b stall=%b lo=%0d hi=%0d want 1/0/10/0",
                 i, bus.div_valid, bus.div_stall, bus.div_lo, bus.div_hi);
      end
    end
    @(posedge clk); #1 bus.e_advance = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.div_valid !== 1'b1) begin failures++; $display("[TB] FAIL hold_advance_cycle got %b want 1", bus.div_valid); end
    release_div(va);
    tests_run++;
    if (va !== 1'b0) begin failures++; $display("[TB] FAIL hold_back_to_idle got %b want 0", va); end
  endtask

  task automatic test_reset_busy();
    @(posedge clk); #1;
    bus.div_start = 1'b1; bus.div_signed = 1'b0; bus.div_a = 32'd77; bus.div_b = 32'd4; bus.e_advance = 1'b1;
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    bus.div_start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.div_valid !== 1'b0 || bus.div_stall !== 1'b0 || bus.div_hi !== 32'h0 || bus.div_lo !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_busy got valid=%b stall=%b hi=%h lo=%h want 0/0/0/0",
               bus.div_valid, bus.div_stall, bus.div_hi, bus.div_lo);
    end
    repeat (40) @(negedge clk);
    tests_run++;
    if (bus.div_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_no_done got %b want 0", bus.div_valid); end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_flush();
    test_hold();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Multi-cycle iterative 32-bit divider serving the execute stage. It executes MIPS DIV and DIVU and produces the divide-stall request that the hazard unit uses to freeze the pipeline. It returns quotient to LO and remainder to HI. The hazard unit's M-stage exception flush cancels an in-flight divide.

## Interface
- WIDTH, 32: operand and result width; the iteration count equals WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- div_start  in  1  E-stage instruction is DIV/DIVU and E is valid; held high while the instruction sits in E.
- div_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled with div_start in IDLE.
- div_a  in  WIDTH  dividend (rs); sampled in IDLE.
- div_b  in  WIDTH  divisor (rt); sampled in IDLE.
- e_advance  in  1  E stage advances this cycle (hazard E_ena and not E_flush).
- flush  in  1  cancel (M_except); highest priority.
- div_stall  out  1  stall request to the hazard unit (E_div_stall).
- div_valid  out  1  hi/lo hold a valid result for the current E instruction.
- div_hi  out  WIDTH  remainder.
- div_lo  out  WIDTH  quotient.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - If div_start and not flush: latch |a|, |b|, the quotient sign (a_sign xor b_sign, signed only) and the remainder sign (a_sign, signed only).
  - If b == 0, go to DONE. Otherwise clear the partial remainder, set count = 0, and go to BUSY.
- BUSY: perform one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Compute trial = rem - b as a WIDTH+1 bit subtraction.
  - If the trial is non-negative, rem = trial and quo[0] = 1.
  - Increment count. When count reaches WIDTH-1 on a step, go to DONE.
- DONE:
  - Apply sign fix-ups (two's complement negate) and register the results into div_hi/div_lo.
  - Hold the results while e_advance is low.
  - When e_advance is high, go to IDLE. No restart occurs in the same cycle, even if div_start is high.
- Divide by zero: div_lo = all ones, div_hi = div_a (raw operand), for both signed and unsigned.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): div_lo = 0x80000000, div_hi = 0. The natural result of the algorithm gives this; no special case is needed.
- div_stall = div_start & ~flush & (state != DONE). It is combinational from the inputs and state.
- div_valid = (state == DONE).
- flush in any state: next state is IDLE, the count is cleared, and div_stall is low in the flush cycle. div_hi/div_lo keep their old values, but div_valid drops.
- div_start falling in BUSY without a flush means the instruction was removed by another path. The unit goes to IDLE next cycle.

## Timing
- Reset values: state IDLE, count 0, div_stall 0 (given div_start low), div_valid 0, div_hi 0, div_lo 0.
- Normal divide, with div_start first high in cycle T:
  - div_stall is high during cycles T..T+WIDTH (33 cycles for WIDTH=32).
  - In cycle T+WIDTH+1 the state is DONE, div_valid = 1, div_stall = 0, and the result is readable combinationally from registers.
- Divide by zero: div_stall is high in cycle T only; the result is valid in T+1.
- Back-to-back divides: the second instruction is sampled one cycle after the DONE → IDLE transition. Minimum spacing is 1 idle cycle.
- A flush in the same cycle as the IDLE sample prevents the capture.
- A flush in the same cycle as the final BUSY step wins; no DONE is entered.
- A synchronous reset mid-operation behaves identically to a flush and also clears hi/lo.

## Structure
- Shared package cdim_div_pkg holds:
  - the state enum {IDLE, BUSY, DONE};
  - the WIDTH default;
  - the divide-by-zero result constants.
- Single module. The restoring step (shift, subtract, select) is a local function and does not warrant a sub-module.
- div_stall connects to the hazard unit's E_div_stall.
- e_advance = E_ena & ~E_flush, taken from the hazard unit.

## Test plan
- DIVU 100/7 with e_advance high → div_stall high for 33 cycles, then div_lo = 14 and div_hi = 2, with div_valid high for one cycle.
- DIV 0xFFFFFFF9 / 2 (-7/2) → div_lo = 0xFFFFFFFD and div_hi = 0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF → div_lo = 0x80000000, div_hi = 0.
- DIVU 5/0 → div_stall high for 1 cycle, then div_lo = 0xFFFFFFFF and div_hi = 5.
- Start a divide, assert flush in BUSY cycle 10 → div_stall low in that cycle, state IDLE next cycle, div_valid never asserted. A new DIVU 9/3 afterwards → div_lo = 3.
- Hold e_advance low for 3 cycles in DONE with div_start still high → no restart, div_stall stays low, results stable. Raise e_advance → IDLE.
- Assert resetn low during BUSY → all outputs return to reset values next cycle.
